// File: rtl/sip_shift_acc.sv
// sip_shift_acc: bit-plane shift-accumulator producing a signed dot product over a valid/ready handshake.
// Build option SIP_ACC_SAT_EN: clamp o_result to the OUT_BITS signed range instead of wrapping.
module sip_shift_acc #(
  parameter int BITS_PSUM = 8,
  parameter int MAX_PREC  = 8,
  parameter int ACC_BITS  = 24,
  parameter int OUT_BITS  = 16
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic [BITS_PSUM-1:0] i_psum,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [$clog2(MAX_PREC)-1:0] i_prec_act,
  input  logic [$clog2(MAX_PREC)-1:0] i_prec_wgt,
  input  logic                 i_signed_act,
  input  logic                 i_signed_wgt,
  output logic [OUT_BITS-1:0]  o_result,
  output logic                 o_valid,
  input  logic                 i_ready
);
  localparam int IW = $clog2(MAX_PREC);
  typedef enum logic {ACC, OUT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] a_idx_q, a_idx_d, w_idx_q, w_idx_d, pa_q, pa_d, pw_q, pw_d, pa, pw;
  logic sa_q, sa_d, sw_q, sw_d, sa, sw;
  logic signed [ACC_BITS-1:0] acc_q, acc_d, ext, sh, term;
  logic [OUT_BITS-1:0] res_q, res_d, res_n;
  logic [IW:0] shamt;
  logic beat, first, last_a, last_w, neg;
  always_ff @(posedge i_CLK or posedge i_RST)
    if (i_RST) begin
      state_q <= ACC;
      a_idx_q <= '0;
      w_idx_q <= '0;
      pa_q    <= '0;
      pw_q    <= '0;
      sa_q    <= 1'b0;
      sw_q    <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_idx_q <= a_idx_d;
      w_idx_q <= w_idx_d;
      pa_q    <= pa_d;
      pw_q    <= pw_d;
      sa_q    <= sa_d;
      sw_q    <= sw_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  always_comb begin
    state_d = state_q;
    if (state_q == ACC && beat && last_a && last_w) state_d = OUT;
    if (state_q == OUT && i_ready) state_d = ACC;
  end
  always_comb begin
    o_ready  = state_q == ACC;
    o_valid  = state_q == OUT;
    o_result = res_q;
  end
  // The (0,0) beat uses the live config, since it is latched on that same beat.
  always_comb begin
    beat   = i_valid & o_ready;
    first  = a_idx_q == '0 && w_idx_q == '0;
    pa     = first ? i_prec_act : pa_q;
    pw     = first ? i_prec_wgt : pw_q;
    sa     = first ? i_signed_act : sa_q;
    sw     = first ? i_signed_wgt : sw_q;
    last_a = a_idx_q == pa;
    last_w = w_idx_q == pw;
    neg    = (sa & last_a) ^ (sw & last_w);
    ext    = {{(ACC_BITS-BITS_PSUM){i_psum[BITS_PSUM-1]}}, i_psum};
    shamt  = {1'b0, a_idx_q} + {1'b0, w_idx_q};
    sh     = ext <<< shamt;
    term   = neg ? -sh : sh;
    acc_d  = beat ? (first ? term : acc_q + term) : acc_q;
    pa_d   = beat && first ? i_prec_act : pa_q;
    pw_d   = beat && first ? i_prec_wgt : pw_q;
    sa_d   = beat && first ? i_signed_act : sa_q;
    sw_d   = beat && first ? i_signed_wgt : sw_q;
    w_idx_d = !beat ? w_idx_q : last_w ? '0 : w_idx_q + IW'(1);
    a_idx_d = !beat || !last_w ? a_idx_q : last_a ? '0 : a_idx_q + IW'(1);
    res_d  = beat && last_a && last_w ? res_n : res_q;
  end
`ifdef SIP_ACC_SAT_EN
  localparam logic signed [ACC_BITS-1:0] SAT_MAX = ACC_BITS'((1 << (OUT_BITS-1)) - 1);
  localparam logic signed [ACC_BITS-1:0] SAT_MIN = ~SAT_MAX;
  always_comb
    res_n = acc_d > SAT_MAX ? SAT_MAX[OUT_BITS-1:0] : acc_d < SAT_MIN ? SAT_MIN[OUT_BITS-1:0] : acc_d[OUT_BITS-1:0];
`else
  always_comb
    res_n = acc_d[OUT_BITS-1:0];
`endif
endmodule

// File: tb/tb_sip_shift_acc.sv
// tb_sip_shift_acc: randomized scoreboard bench for sip_shift_acc against an arithmetic dot-product model.
module tb_sip_shift_acc;
  logic i_CLK = 0, i_RST = 1;
  logic [7:0] i_psum = '0;
  logic i_valid = 0, o_ready;
  logic [2:0] i_prec_act = '0, i_prec_wgt = '0;
  logic i_signed_act = 0, i_signed_wgt = 0;
  logic signed [15:0] o_result;
  logic o_valid, i_ready = 1;
  int tests = 0, fails = 0, stall_cycles = 0;
  int psv[64];
  logic signed [15:0] sb[$];

  sip_shift_acc dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_psum(i_psum), .i_valid(i_valid), .o_ready(o_ready),
    .i_prec_act(i_prec_act), .i_prec_wgt(i_prec_wgt), .i_signed_act(i_signed_act),
    .i_signed_wgt(i_signed_wgt), .o_result(o_result), .o_valid(o_valid), .i_ready(i_ready)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [15:0] expect_of(input longint s);
`ifdef SIP_ACC_SAT_EN
    return s > 32767 ? 16'sh7fff : s < -32768 ? 16'sh8000 : 16'(s);
`else
    return 16'(s);
`endif
  endfunction

  initial forever begin
    @(posedge i_CLK);
    #2;
    if (stall_cycles > 0) begin
      i_ready = 0;
      stall_cycles--;
    end else i_ready = $urandom_range(0, 3) != 0;
  end

  always @(negedge i_CLK)
    if (!i_RST && o_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %0d, expected no output", o_result);
      end else begin
        check("result", o_result, sb[0]);
        check("ready_low_in_out", o_ready, 0);
        if (i_ready) void'(sb.pop_front());
      end
    end

  task automatic beat(input int p, input int pa, input int pw, input bit sa, input bit sw, input bit cfg);
    int n = 0;
    repeat ($urandom_range(0, 1)) begin
      i_valid = 0;
      i_psum = 8'($urandom);
      @(posedge i_CLK);
      #1;
    end
    i_psum = 8'(p);
    i_valid = 1;
    i_prec_act = cfg ? 3'(pa - 1) : 3'($urandom);
    i_prec_wgt = cfg ? 3'(pw - 1) : 3'($urandom);
    i_signed_act = cfg ? sa : 1'($urandom);
    i_signed_wgt = cfg ? sw : 1'($urandom);
    forever begin
      @(negedge i_CLK);
      if (o_ready) break;
      if (++n > 200) begin
        tests++;
        fails++;
        $display("FAIL beat_timeout: got no o_ready, expected o_ready within 200 cycles");
        break;
      end
    end
    @(posedge i_CLK);
    #1;
    i_valid = 0;
  endtask

  task automatic run_op(input int pa, input int pw, input bit sa, input bit sw, input int stall);
    longint s = 0;
    for (int a = 0; a < pa; a++)
      for (int w = 0; w < pw; w++) begin
        longint t = longint'(psv[a*pw+w]) * (longint'(1) << (a + w));
        s += ((sa && a == pa-1) ^ (sw && w == pw-1)) ? -t : t;
      end
    sb.push_back(expect_of(s));
    for (int i = 0; i < pa*pw; i++) beat(psv[i], pa, pw, sa, sw, i == 0);
    check("latency_valid", o_valid, 1);
    check("latency_ready", o_ready, 0);
    stall_cycles = stall;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 || o_valid) begin
      @(posedge i_CLK);
      #1;
      if (++n > 300) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        break;
      end
    end
  endtask

  initial begin
    #12;
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_result", o_result, 0);
    @(posedge i_CLK);
    #1;
    i_RST = 0;
    psv[0] = 5;
    run_op(1, 1, 0, 0, 0);
    psv[0] = 1; psv[1] = 2; psv[2] = 3; psv[3] = 4;
    run_op(2, 2, 0, 0, 0);
    run_op(2, 2, 1, 1, 0);
    run_op(2, 2, 0, 0, 3);
    drain();
    beat(7, 2, 2, 0, 0, 1);
    beat(9, 2, 2, 0, 0, 0);
    #2;
    i_RST = 1;
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_ready", o_ready, 1);
    check("midrst_result", o_result, 0);
    @(posedge i_CLK);
    #1;
    i_RST = 0;
    psv[0] = 3;
    run_op(1, 1, 0, 0, 0);
    for (int i = 0; i < 64; i++) psv[i] = 127;
    run_op(8, 8, 0, 0, 0);
    for (int i = 0; i < 64; i++) psv[i] = -128;
    run_op(8, 8, 1, 0, 0);
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 64; i++) psv[i] = int'($urandom_range(0, 255)) - 128;
      run_op(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
